// File: rtl/mem_arbiter_2p.sv
// rtl/mem_arbiter_2p.sv - two-port round-robin arbiter onto one valid/ready memory port
// Serialises whole transactions, alternates on contention, aborts hung ones via a watchdog.
module mem_arbiter_2p #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_mem_valid,
  input  logic [31:0] m0_mem_addr,
  input  logic [3:0]  m0_mem_wstrb,
  input  logic [31:0] m0_mem_wdata,
  output logic        m0_mem_ready,
  output logic [31:0] m0_mem_rdata,
  input  logic        m1_mem_valid,
  input  logic [31:0] m1_mem_addr,
  input  logic [3:0]  m1_mem_wstrb,
  input  logic [31:0] m1_mem_wdata,
  output logic        m1_mem_ready,
  output logic [31:0] m1_mem_rdata,
  output logic        s_mem_valid,
  output logic [31:0] s_mem_addr,
  output logic [3:0]  s_mem_wstrb,
  output logic [31:0] s_mem_wdata,
  input  logic        s_mem_ready,
  input  logic [31:0] s_mem_rdata,
  output logic        busy,
  output logic        grant_id,
  output logic        err_timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state;
  state_t           state_next;
  logic             grant_q;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;
  logic             err_q;
  logic             pick;
  logic             abort;
  logic             done;
  logic [31:0]      rdata_mux;

  // A ready arriving in the timeout cycle wins over the abort.
  assign abort = (state == BUSY) && (TIMEOUT != 0) && (cnt == TIMEOUT_C) && !s_mem_ready;
  assign done  = (state == BUSY) && (s_mem_ready || abort);
  assign pick  = (m0_mem_valid && m1_mem_valid) ? ~last_grant : m1_mem_valid;
  assign rdata_mux = abort ? 32'hDEAD_BEEF : s_mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (m0_mem_valid || m1_mem_valid) state_next = BUSY;
      BUSY:    if (done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q    <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      err_q      <= 1'b0;
    end else if (state == IDLE) begin
      if (m0_mem_valid || m1_mem_valid) begin
        grant_q <= pick;
        cnt     <= '0;
      end
    end else begin
      if (done) last_grant <= grant_q;
      if (abort) err_q <= 1'b1;
      if (!s_mem_ready && cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    s_mem_valid  = 1'b0;
    s_mem_addr   = '0;
    s_mem_wstrb  = '0;
    s_mem_wdata  = '0;
    m0_mem_ready = 1'b0;
    m0_mem_rdata = '0;
    m1_mem_ready = 1'b0;
    m1_mem_rdata = '0;
    if (state == BUSY) begin
      s_mem_valid = !abort;
      s_mem_addr  = grant_q ? m1_mem_addr  : m0_mem_addr;
      s_mem_wstrb = grant_q ? m1_mem_wstrb : m0_mem_wstrb;
      s_mem_wdata = grant_q ? m1_mem_wdata : m0_mem_wdata;
      if (grant_q) begin
        m1_mem_ready = done;
        m1_mem_rdata = done ? rdata_mux : 32'h0;
      end else begin
        m0_mem_ready = done;
        m0_mem_rdata = done ? rdata_mux : 32'h0;
      end
    end
  end

  assign busy        = (state == BUSY);
  assign grant_id    = grant_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// tb/tb_mem_arbiter_2p.sv - self-checking bench for mem_arbiter_2p
// Fixed vector table, directed corner sequences and a randomized run against a transaction-level model.
module tb_mem_arbiter_2p;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_mem_valid, m1_mem_valid;
  logic [31:0] m0_mem_addr, m1_mem_addr, m0_mem_wdata, m1_mem_wdata;
  logic [3:0]  m0_mem_wstrb, m1_mem_wstrb;
  logic        m0_mem_ready, m1_mem_ready;
  logic [31:0] m0_mem_rdata, m1_mem_rdata;
  logic        s_mem_valid;
  logic [31:0] s_mem_addr, s_mem_wdata;
  logic [3:0]  s_mem_wstrb;
  logic        s_mem_ready;
  logic [31:0] s_mem_rdata;
  logic        busy, grant_id, err_timeout;

  mem_arbiter_2p #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .m0_mem_valid(m0_mem_valid), .m0_mem_addr(m0_mem_addr), .m0_mem_wstrb(m0_mem_wstrb),
    .m0_mem_wdata(m0_mem_wdata), .m0_mem_ready(m0_mem_ready), .m0_mem_rdata(m0_mem_rdata),
    .m1_mem_valid(m1_mem_valid), .m1_mem_addr(m1_mem_addr), .m1_mem_wstrb(m1_mem_wstrb),
    .m1_mem_wdata(m1_mem_wdata), .m1_mem_ready(m1_mem_ready), .m1_mem_rdata(m1_mem_rdata),
    .s_mem_valid(s_mem_valid), .s_mem_addr(s_mem_addr), .s_mem_wstrb(s_mem_wstrb),
    .s_mem_wdata(s_mem_wdata), .s_mem_ready(s_mem_ready), .s_mem_rdata(s_mem_rdata),
    .busy(busy), .grant_id(grant_id), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: who owns the memory, how long it has waited, who went last.
  int owner, last, gid, waited;
  bit err;

  task automatic model_reset();
    owner = -1; last = 1; gid = 0; waited = 0; err = 0;
  endtask

  logic        o_m0r, o_m1r, o_sv, o_busy, o_gid, o_err;
  logic [31:0] o_m0d, o_m1d, o_saddr, o_swdata;
  logic [3:0]  o_swstrb;

  task automatic capture();
    o_m0r = m0_mem_ready; o_m0d = m0_mem_rdata; o_m1r = m1_mem_ready; o_m1d = m1_mem_rdata;
    o_sv = s_mem_valid; o_saddr = s_mem_addr; o_swstrb = s_mem_wstrb; o_swdata = s_mem_wdata;
    o_busy = busy; o_gid = grant_id; o_err = err_timeout;
  endtask

  // Called at a negedge: drive, compare against the model, let one rising edge pass.
  task automatic step(input bit v0, input bit v1, input bit sr, input logic [31:0] srd);
    bit mbusy, to, done;
    logic [31:0] rd;
    m0_mem_valid = v0; m1_mem_valid = v1; s_mem_ready = sr; s_mem_rdata = srd;
    #1;
    capture();
    mbusy = (owner >= 0);
    to    = mbusy && (waited == TO) && !sr;
    done  = mbusy && (sr || to);
    rd    = to ? 32'hDEAD_BEEF : srd;
    check("m0_ready", o_m0r, 32'(done && owner == 0));
    check("m0_rdata", o_m0d, (done && owner == 0) ? rd : 32'h0);
    check("m1_ready", o_m1r, 32'(done && owner == 1));
    check("m1_rdata", o_m1d, (done && owner == 1) ? rd : 32'h0);
    check("s_valid", o_sv, 32'(mbusy && !to));
    check("s_addr", o_saddr, !mbusy ? 32'h0 : (owner == 1 ? m1_mem_addr : m0_mem_addr));
    check("s_wstrb", 32'(o_swstrb), !mbusy ? 32'h0 : 32'(owner == 1 ? m1_mem_wstrb : m0_mem_wstrb));
    check("s_wdata", o_swdata, !mbusy ? 32'h0 : (owner == 1 ? m1_mem_wdata : m0_mem_wdata));
    check("busy", o_busy, 32'(mbusy));
    if (mbusy) check("grant_id", o_gid, 32'(gid));
    check("err_timeout", o_err, 32'(err));
    @(posedge clk);
    if (!mbusy) begin
      if (v0 || v1) begin
        owner = (v0 && v1) ? (1 - last) : (v1 ? 1 : 0);
        gid = owner; waited = 0;
      end
    end else if (done) begin
      last = owner;
      if (to) err = 1;
      owner = -1;
    end else begin
      waited++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; m0_mem_valid = 0; m1_mem_valid = 0; s_mem_ready = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit v0, v1, sr; logic [31:0] srd;
    bit e0r, e1r; logic [31:0] e0d, e1d; bit esv, ebusy, egid;
  } vec_t;

  vec_t tbl[16];
  bit   pend0, pend1;

  initial begin
    reset = 1'b1;
    m0_mem_valid = 0; m1_mem_valid = 0; s_mem_ready = 0; s_mem_rdata = 0;
    m0_mem_addr = 32'h100; m1_mem_addr = 32'h200;
    m0_mem_wstrb = 0; m1_mem_wstrb = 0; m0_mem_wdata = 32'h0; m1_mem_wdata = 32'h0;
    model_reset();

    //          v0 v1 sr srd          e0r e1r e0d          e1d          sv busy gid
    tbl[0]  = '{0, 0, 0, 32'h0,       0,  0,  32'h0,       32'h0,       0, 0,   0};
    tbl[1]  = '{0, 0, 1, 32'h11,      0,  0,  32'h0,       32'h0,       0, 0,   0};
    tbl[2]  = '{1, 1, 0, 32'h0,       0,  0,  32'h0,       32'h0,       0, 0,   0};
    tbl[3]  = '{1, 1, 0, 32'h0,       0,  0,  32'h0,       32'h0,       1, 1,   0};
    tbl[4]  = '{1, 1, 1, 32'h44,      1,  0,  32'h44,      32'h0,       1, 1,   0};
    tbl[5]  = '{1, 1, 0, 32'h0,       0,  0,  32'h0,       32'h0,       0, 0,   0};
    tbl[6]  = '{1, 1, 0, 32'h66,      0,  0,  32'h0,       32'h0,       1, 1,   1};
    tbl[7]  = '{1, 1, 1, 32'h77,      0,  1,  32'h0,       32'h77,      1, 1,   1};
    tbl[8]  = '{1, 1, 0, 32'h0,       0,  0,  32'h0,       32'h0,       0, 0,   1};
    tbl[9]  = '{1, 1, 0, 32'h0,       0,  0,  32'h0,       32'h0,       1, 1,   0};
    tbl[10] = '{1, 1, 1, 32'hAA,      1,  0,  32'hAA,      32'h0,       1, 1,   0};
    tbl[11] = '{0, 0, 0, 32'h0,       0,  0,  32'h0,       32'h0,       0, 0,   0};
    tbl[12] = '{0, 1, 0, 32'h0,       0,  0,  32'h0,       32'h0,       0, 0,   0};
    tbl[13] = '{0, 1, 0, 32'h0,       0,  0,  32'h0,       32'h0,       1, 1,   1};
    tbl[14] = '{0, 1, 1, 32'hEE,      0,  1,  32'h0,       32'hEE,      1, 1,   1};
    tbl[15] = '{0, 0, 0, 32'h0,       0,  0,  32'h0,       32'h0,       0, 0,   1};

    do_reset();
    check("reset_err", 32'(err_timeout), 32'h0);
    for (int i = 0; i < 16; i++) begin
      m0_mem_valid = tbl[i].v0; m1_mem_valid = tbl[i].v1;
      s_mem_ready = tbl[i].sr; s_mem_rdata = tbl[i].srd;
      #1;
      check($sformatf("tbl%0d_m0r", i), 32'(m0_mem_ready), 32'(tbl[i].e0r));
      check($sformatf("tbl%0d_m1r", i), 32'(m1_mem_ready), 32'(tbl[i].e1r));
      check($sformatf("tbl%0d_m0d", i), m0_mem_rdata, tbl[i].e0d);
      check($sformatf("tbl%0d_m1d", i), m1_mem_rdata, tbl[i].e1d);
      check($sformatf("tbl%0d_sv", i), 32'(s_mem_valid), 32'(tbl[i].esv));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].ebusy));
      check($sformatf("tbl%0d_gid", i), 32'(grant_id), 32'(tbl[i].egid));
      @(posedge clk);
      @(negedge clk);
    end

    // Port 0 read answered three cycles after valid.
    do_reset();
    m0_mem_addr = 32'h0000_0010; m0_mem_wstrb = 4'h0;
    step(1, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0);
    check("rd_addr", o_saddr, 32'h10);
    step(1, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0);
    step(1, 0, 1, 32'h1234_5678);
    check("rd_ready", 32'(o_m0r), 32'h1);
    check("rd_data", o_m0d, 32'h1234_5678);
    check("rd_m1_quiet", 32'(o_m1r), 32'h0);
    step(0, 0, 0, 32'h0);
    check("rd_gap", 32'(o_sv), 32'h0);

    // Port 1 write muxing.
    m1_mem_addr = 32'h40; m1_mem_wstrb = 4'b0011; m1_mem_wdata = 32'hAABB_CCDD;
    step(0, 1, 0, 32'h0);
    step(0, 1, 0, 32'h0);
    check("wr_addr", o_saddr, 32'h40);
    check("wr_wstrb", 32'(o_swstrb), 32'h3);
    check("wr_wdata", o_swdata, 32'hAABB_CCDD);
    step(0, 1, 1, 32'h0);
    check("wr_ready", 32'(o_m1r), 32'h1);
    step(0, 0, 0, 32'h0);

    // Ready coinciding with the timeout count is a normal completion.
    do_reset();
    step(1, 0, 0, 32'h0);
    for (int i = 0; i < TO; i++) step(1, 0, 0, 32'h0);
    step(1, 0, 1, 32'h5555_0001);
    check("edge_ready", 32'(o_m0r), 32'h1);
    check("edge_data", o_m0d, 32'h5555_0001);
    step(0, 0, 0, 32'h0);
    check("edge_no_err", 32'(o_err), 32'h0);

    // Memory never answers port 0: abort after TO busy cycles.
    step(1, 0, 0, 32'h0);
    for (int i = 0; i < TO; i++) begin
      step(1, 0, 0, 32'h0);
      check("to_wait_sv", 32'(o_sv), 32'h1);
    end
    step(1, 0, 0, 32'h0);
    check("to_ready", 32'(o_m0r), 32'h1);
    check("to_data", o_m0d, 32'hDEAD_BEEF);
    check("to_sv_low", 32'(o_sv), 32'h0);
    step(0, 0, 0, 32'h0);
    check("to_err", 32'(o_err), 32'h1);
    step(0, 1, 0, 32'h0);
    step(0, 1, 1, 32'hCAFE_0001);
    check("to_next_ready", 32'(o_m1r), 32'h1);
    check("to_next_data", o_m1d, 32'hCAFE_0001);
    step(0, 0, 0, 32'h0);
    check("to_err_sticky", 32'(o_err), 32'h1);

    // Reset while port 1 is granted.
    step(0, 1, 0, 32'h0);
    step(0, 1, 0, 32'h0);
    check("rst_pre_gid", 32'(o_gid), 32'h1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; m1_mem_valid = 0;
    model_reset();
    step(0, 0, 0, 32'h0);
    check("rst_sv", 32'(o_sv), 32'h0);
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_no_ready", 32'(o_m0r | o_m1r), 32'h0);
    check("rst_err", 32'(o_err), 32'h0);
    step(1, 1, 0, 32'h0);
    step(1, 1, 0, 32'h0);
    check("rst_tie_gid", 32'(o_gid), 32'h0);
    step(1, 1, 1, 32'h0);

    // Randomized traffic; masters hold valid until their ready.
    do_reset();
    pend0 = 0; pend1 = 0;
    for (int c = 0; c < 600; c++) begin
      if (!pend0 && ($urandom % 3 == 0)) begin
        pend0 = 1; m0_mem_addr = $urandom; m0_mem_wstrb = 4'($urandom); m0_mem_wdata = $urandom;
      end
      if (!pend1 && ($urandom % 3 == 0)) begin
        pend1 = 1; m1_mem_addr = $urandom; m1_mem_wstrb = 4'($urandom); m1_mem_wdata = $urandom;
      end
      step(pend0, pend1, ($urandom % 4 == 0), $urandom);
      if (o_m0r) pend0 = 0;
      if (o_m1r) pend1 = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
